// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate generation, control decode, load-use stall, ID/EX register.
// Define DECODE_WB_BYPASS_EN to make same-cycle writeback visible to the operands being decoded.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_instruction,
  input  logic [31:0] if_id_pc,
  input  logic        flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_funct7b5,
  output logic [6:0]  id_ex_opcode,
  output logic [7:0]  id_ex_ctrl
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Sign-extended immediate for the instruction's format; zero for R-type and illegal opcodes.
  function automatic logic signed [31:0] gen_imm(input logic [31:0] ins);
    logic signed [31:0] imm;
    imm = '0;
    case (ins[6:0])
      OP_IALU, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BR:                     imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_JAL:                    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      OP_LUI, OP_AUIPC:          imm = {ins[31:12], 12'b0};
      default:                   imm = '0;
    endcase
    return imm;
  endfunction

  logic [31:0]        regs [32];
  logic [6:0]         opcode_p0;
  logic [4:0]         rs1_p0, rs2_p0, rd_p0;
  logic [7:0]         ctrl_p0;
  logic               use_rs1_p0, use_rs2_p0;
  logic signed [31:0] imm_p0;
  logic [31:0]        rs1_data_p0, rs2_data_p0;

  assign opcode_p0 = if_id_instruction[6:0];
  assign rd_p0     = if_id_instruction[11:7];
  assign rs1_p0    = if_id_instruction[19:15];
  assign rs2_p0    = if_id_instruction[24:20];
  assign imm_p0    = gen_imm(if_id_instruction);

  // ctrl: [0] reg_write [1] mem_read [2] mem_write [3] mem_to_reg [4] alu_src [5] branch [6] jump [7] illegal
  always_comb begin
    ctrl_p0    = 8'h00;
    use_rs1_p0 = 1'b0;
    use_rs2_p0 = 1'b0;
    case (opcode_p0)
      OP_R:             begin ctrl_p0 = 8'h01; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; end
      OP_IALU:          begin ctrl_p0 = 8'h11; use_rs1_p0 = 1'b1; end
      OP_LOAD:          begin ctrl_p0 = 8'h1B; use_rs1_p0 = 1'b1; end
      OP_STORE:         begin ctrl_p0 = 8'h14; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; end
      OP_BR:            begin ctrl_p0 = 8'h20; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; end
      OP_JAL:           ctrl_p0 = 8'h41;
      OP_JALR:          begin ctrl_p0 = 8'h51; use_rs1_p0 = 1'b1; end
      OP_LUI, OP_AUIPC: ctrl_p0 = 8'h11;
      default:          ctrl_p0 = 8'h80;
    endcase
  end

  always_comb begin
    rs1_data_p0 = (rs1_p0 == 5'd0) ? 32'd0 : regs[rs1_p0];
    rs2_data_p0 = (rs2_p0 == 5'd0) ? 32'd0 : regs[rs2_p0];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1_p0) rs1_data_p0 = wb_data;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2_p0) rs2_data_p0 = wb_data;
`endif
  end

  // Load in EX whose destination feeds a source this instruction actually reads.
  assign stall = id_ex_ctrl[1] && (id_ex_rd != 5'd0) && !flush &&
                 ((use_rs1_p0 && rs1_p0 == id_ex_rd) || (use_rs2_p0 && rs2_p0 == id_ex_rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX boundary: reset, flush and stall all register a zero bubble.
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_funct3   <= '0;
      id_ex_funct7b5 <= 1'b0;
      id_ex_opcode   <= '0;
      id_ex_ctrl     <= '0;
    end else begin
      id_ex_pc       <= if_id_pc;
      id_ex_rs1_data <= rs1_data_p0;
      id_ex_rs2_data <= rs2_data_p0;
      id_ex_imm      <= $unsigned(imm_p0);
      id_ex_rs1      <= rs1_p0;
      id_ex_rs2      <= rs2_p0;
      id_ex_rd       <= rd_p0;
      id_ex_funct3   <= if_id_instruction[14:12];
      id_ex_funct7b5 <= if_id_instruction[30];
      id_ex_opcode   <= opcode_p0;
      id_ex_ctrl     <= ctrl_p0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts each ID/EX bundle and the stall request.
module tb_decode_stage;

  logic        clk, reset, flush, wb_reg_write;
  logic [31:0] if_id_instruction, if_id_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic [6:0]  id_ex_opcode;
  logic [7:0]  id_ex_ctrl;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1),
    .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b5(id_ex_funct7b5), .id_ex_opcode(id_ex_opcode), .id_ex_ctrl(id_ex_ctrl)
  );

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic [7:0]  ctrl;
  } bundle_t;

  bundle_t     sb[$];
  logic [31:0] m_regs [32];
  logic [7:0]  m_prev_ctrl;
  logic [4:0]  m_prev_rd;
  logic        dut_stall_seen;
  int          n_err = 0;
  int          n_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void model_dec(input logic [31:0] i, output logic [7:0] c,
                                    output logic [31:0] imm, output logic u1, output logic u2);
    c = 8'h80; imm = 32'd0; u1 = 1'b0; u2 = 1'b0;
    case (i[6:0])
      7'h33: begin c = 8'h01; u1 = 1'b1; u2 = 1'b1; end
      7'h13: begin c = 8'h11; u1 = 1'b1; imm = {{20{i[31]}}, i[31:20]}; end
      7'h03: begin c = 8'h1B; u1 = 1'b1; imm = {{20{i[31]}}, i[31:20]}; end
      7'h23: begin c = 8'h14; u1 = 1'b1; u2 = 1'b1; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin c = 8'h20; u1 = 1'b1; u2 = 1'b1;
                   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
      7'h6F: begin c = 8'h41; imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
      7'h67: begin c = 8'h51; u1 = 1'b1; imm = {{20{i[31]}}, i[31:20]}; end
      7'h37, 7'h17: begin c = 8'h11; imm = {i[31:12], 12'h000}; end
      default: ;
    endcase
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic rst);
    logic [7:0]  c;
    logic [31:0] imm, r1, r2;
    logic        u1, u2, st;
    bundle_t     e, g;
    @(negedge clk);
    if_id_instruction = ins; if_id_pc = pc; flush = fl;
    wb_reg_write = we; wb_rd = wrd; wb_data = wdat; reset = rst;
    #1;
    model_dec(ins, c, imm, u1, u2);
    r1 = (ins[19:15] == 5'd0) ? 32'd0 : m_regs[ins[19:15]];
    r2 = (ins[24:20] == 5'd0) ? 32'd0 : m_regs[ins[24:20]];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wrd != 5'd0 && wrd == ins[19:15]) r1 = wdat;
    if (we && wrd != 5'd0 && wrd == ins[24:20]) r2 = wdat;
`endif
    st = m_prev_ctrl[1] && m_prev_rd != 5'd0 && !fl &&
         ((u1 && ins[19:15] == m_prev_rd) || (u2 && ins[24:20] == m_prev_rd));
    dut_stall_seen = stall;
    if (!rst) check("stall", {31'd0, stall}, {31'd0, st});
    if (rst || fl || st) e = '0;
    else e = '{pc: pc, rs1d: r1, rs2d: r2, imm: imm, rs1: ins[19:15], rs2: ins[24:20],
               rd: ins[11:7], f3: ins[14:12], f7: ins[30], op: ins[6:0], ctrl: c};
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("pc",   id_ex_pc, g.pc);
    check("rs1d", id_ex_rs1_data, g.rs1d);
    check("rs2d", id_ex_rs2_data, g.rs2d);
    check("imm",  id_ex_imm, g.imm);
    check("idx",  {17'd0, id_ex_rs1, id_ex_rs2, id_ex_rd}, {17'd0, g.rs1, g.rs2, g.rd});
    check("fld",  {21'd0, id_ex_funct3, id_ex_funct7b5, id_ex_opcode}, {21'd0, g.f3, g.f7, g.op});
    check("ctrl", {24'd0, id_ex_ctrl}, {24'd0, g.ctrl});
    m_prev_ctrl = g.ctrl;
    m_prev_rd   = g.rd;
    if (rst) for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    else if (we && wrd != 5'd0) m_regs[wrd] = wdat;
  endtask

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ADD_1_5  = 32'h000280B3;
  localparam logic [31:0] ADDI_4_3 = 32'hFFF18213;
  localparam logic [31:0] LW_6_2   = 32'h00012303;
  localparam logic [31:0] ADD_7_6  = 32'h001303B3;
  localparam logic [31:0] LW_0_2   = 32'h00012003;
  localparam logic [31:0] ADD_7_0  = 32'h001003B3;
  localparam logic [31:0] BEQ      = 32'hFE208CE3;
  localparam logic [31:0] ILLEGAL  = 32'h0000007F;
  localparam logic [31:0] ADDI_1_0 = 32'h00000093;

  initial begin
    logic [31:0] old_x3, ins, pc;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    reset = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    if_id_instruction = NOP; if_id_pc = '0;
    m_prev_ctrl = '0; m_prev_rd = '0; dut_stall_seen = 1'b0;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;

    step(NOP, 32'h0, 1'b0, 1'b1, 5'd5, 32'hFFFF0000, 1'b1);
    step(NOP, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    step(ADD_1_5, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("x5_reset", id_ex_rs1_data, 32'h0);

    // Write x3 then decode next cycle
    step(NOP, 32'h104, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    step(ADDI_4_3, 32'h108, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("addi_rs1", id_ex_rs1_data, 32'hDEADBEEF);
    check("addi_imm", id_ex_imm, 32'hFFFFFFFF);
    check("addi_ctrl", {24'd0, id_ex_ctrl}, 32'h11);

    // Same-cycle writeback and decode
    step(NOP, 32'h10C, 1'b0, 1'b1, 5'd3, 32'h11111111, 1'b0);
    old_x3 = 32'h11111111;
    step(ADDI_4_3, 32'h110, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
`ifdef DECODE_WB_BYPASS_EN
    check("same_cyc", id_ex_rs1_data, 32'hDEADBEEF);
`else
    check("same_cyc", id_ex_rs1_data, old_x3);
`endif

    // Load-use
    step(LW_6_2, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(ADD_7_6, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("lu_stall", {31'd0, dut_stall_seen}, 32'd1);
    step(ADD_7_6, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("lu_stall_clear", {31'd0, dut_stall_seen}, 32'd0);
    check("lu_add_ctrl", {24'd0, id_ex_ctrl}, 32'h01);
    step(LW_0_2, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(ADD_7_0, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("lu_x0_nostall", {31'd0, dut_stall_seen}, 32'd0);

    // Flush overrides stall
    step(LW_6_2, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(ADD_7_6, 32'h128, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    check("fl_stall", {31'd0, dut_stall_seen}, 32'd0);
    check("fl_bubble", {24'd0, id_ex_ctrl}, 32'h0);
    step(BEQ, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("beq_imm", id_ex_imm, 32'hFFFFFFF8);
    check("beq_ctrl", {24'd0, id_ex_ctrl}, 32'h20);

    step(ILLEGAL, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("ill_ctrl", {24'd0, id_ex_ctrl}, 32'h80);
    check("ill_imm", id_ex_imm, 32'h0);
    step(NOP, 32'h134, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b0);
    step(ADDI_1_0, 32'h138, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("x0_read", id_ex_rs1_data, 32'h0);

    // Other formats
    step(32'h0050A223, 32'h13C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(32'h010000EF, 32'h140, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(32'hABCDE2B7, 32'h144, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(32'h000280E7, 32'h148, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

    // Reset during a load-use stall with a pending writeback
    step(LW_6_2, 32'h14C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(ADD_7_6, 32'h150, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1);
    check("rst_mid_ctrl", {24'd0, id_ex_ctrl}, 32'h0);
    step(ADD_7_6, 32'h150, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("rst_mid_stall", {31'd0, dut_stall_seen}, 32'd0);

    // Random traffic
    pc = 32'h200;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) ins[19:15] = m_prev_rd;
      step(ins, pc, ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, 1'b0);
      pc = pc + 32'd4;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
